rs_enc_stream: RTL and testbench

RS_ENC_STREAM -- requirements
Module: rs_enc_stream

---
 rtl/rs_enc_stream.sv | 96 +++++++++
 tb/tb_rs_enc_stream.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rs_enc_stream.sv
// rs_enc_stream: streaming systematic RS-style encoder over GF(2^8) (poly 0x15F),
// appending P = XOR of symbols and Q = sum alpha^i * d_i to each K-symbol codeword.
module rs_enc_stream #(
    parameter int K         = 8,
    parameter int BEAT_SYMS = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [BEAT_SYMS*8-1:0]   s_data,
    input  logic                     s_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [(K+2)*8-1:0]       m_codeword,
    output logic                     err,
    output logic [15:0]              err_cnt
);
    localparam int NB = K / BEAT_SYMS;
    localparam int BW = BEAT_SYMS * 8;
    localparam int CW = NB > 1 ? $clog2(NB) : 1;

    logic [CW-1:0]  cnt;
    logic [7:0]     p, q, pw, p_nxt, q_nxt, pw_nxt;
    logic [K*8-1:0] data_buf, data_nxt;
    logic           acc, at_end, fin, ferr;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h5f : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            r = b[i] ? r ^ x : r;
            x = xtime(x);
        end
        return r;
    endfunction

    assign s_ready = !m_valid || m_ready;
    assign acc     = s_valid && s_ready;
    assign at_end  = cnt == CW'(NB - 1);
    assign fin     = acc && s_last && at_end;
    assign ferr    = acc && (s_last != at_end);

    // pw_nxt walks pw*alpha^j across the beat and ends at pw*alpha^BEAT_SYMS
    always_comb begin
        p_nxt  = p;
        q_nxt  = q;
        pw_nxt = pw;
        for (int j = 0; j < BEAT_SYMS; j++) begin
            p_nxt  = p_nxt ^ s_data[(BEAT_SYMS-1-j)*8 +: 8];
            q_nxt  = q_nxt ^ gmul(pw_nxt, s_data[(BEAT_SYMS-1-j)*8 +: 8]);
            pw_nxt = xtime(pw_nxt);
        end
    end

    always_comb begin
        data_nxt = data_buf;
        data_nxt[(NB-1-int'(cnt))*BW +: BW] = s_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            p          <= '0;
            q          <= '0;
            pw         <= 8'h01;
            data_buf   <= '0;
            m_valid    <= 1'b0;
            m_codeword <= '0;
            err        <= 1'b0;
            err_cnt    <= '0;
        end else begin
            err <= ferr;
            if (ferr && err_cnt != 16'hffff)
                err_cnt <= err_cnt + 16'd1;
            if (fin) begin
                m_valid    <= 1'b1;
                m_codeword <= {data_nxt, p_nxt, q_nxt};
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
            if (acc) begin
                cnt      <= (fin || ferr) ? '0 : cnt + 1'b1;
                p        <= (fin || ferr) ? 8'h00 : p_nxt;
                q        <= (fin || ferr) ? 8'h00 : q_nxt;
                pw       <= (fin || ferr) ? 8'h01 : pw_nxt;
                data_buf <= data_nxt;
            end
        end
    end
endmodule

// File: tb/tb_rs_enc_stream.sv
// tb_rs_enc_stream: directed and random codewords checked against a plain-arithmetic
// GF(2^8) model of the systematic P/Q codeword.
module tb_rs_enc_stream;
    localparam int K   = 8;
    localparam int BS  = 2;
    localparam int NB  = K / BS;
    localparam int CWB = (K + 2) * 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [BS*8-1:0]  s_data = '0;
    logic             s_last = 1'b0;
    logic             m_valid;
    logic             m_ready = 1'b1;
    logic [CWB-1:0]   m_codeword;
    logic             err;
    logic [15:0]      err_cnt;

    int total = 0;
    int bad = 0;
    logic [7:0]     sym [K];
    logic [CWB-1:0] saved;
    logic [BS*8-1:0] bd;

    rs_enc_stream #(.K(K), .BEAT_SYMS(BS)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
        .m_codeword(m_codeword), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // carry-less product then polynomial long division by 0x15F
    function automatic logic [7:0] gf_ref(input int a, input int b);
        int prod = 0;
        for (int i = 0; i < 8; i++)
            if (((b >> i) & 1) != 0) prod = prod ^ (a << i);
        for (int k = 14; k >= 8; k--)
            if (((prod >> k) & 1) != 0) prod = prod ^ ('h15f << (k - 8));
        return 8'(prod);
    endfunction

    function automatic logic [CWB-1:0] model();
        logic [CWB-1:0] cw = '0;
        int p = 0, q = 0, ap = 1;
        for (int i = 0; i < K; i++) begin
            cw[(K+1-i)*8 +: 8] = sym[i];
            p  = p ^ int'(sym[i]);
            q  = q ^ int'(gf_ref(ap, int'(sym[i])));
            ap = int'(gf_ref(ap, 2));
        end
        cw[15:8] = 8'(p);
        cw[7:0]  = 8'(q);
        return cw;
    endfunction

    task automatic chk(input string tag, input logic [CWB-1:0] obs, input logic [CWB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic beat_of(input int b, output logic [BS*8-1:0] d);
        for (int j = 0; j < BS; j++) d[(BS-1-j)*8 +: 8] = sym[b*BS+j];
    endtask

    task automatic beat(input logic [BS*8-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_cw();
        logic [BS*8-1:0] d;
        for (int b = 0; b < NB; b++) begin
            beat_of(b, d);
            beat(d, b == NB - 1);
        end
    endtask

    task automatic rand_sym();
        for (int i = 0; i < K; i++) sym[i] = 8'($urandom);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_codeword", m_codeword, 0);
        chk("rst_err", err, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_s_ready", s_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        idle();

        for (int i = 0; i < K; i++) sym[i] = 8'(i + 1);
        send_cw();
        chk("vec_m_valid", m_valid, 1);
        chk("vec_codeword", m_codeword, 80'h0102030405060708_0805);
        chk("vec_model", m_codeword, model());

        for (int i = 0; i < K; i++) sym[i] = 8'h00;
        sym[K-1] = 8'h01;
        send_cw();
        chk("d7_pq", m_codeword[15:0], 16'h0180);
        for (int i = 0; i < K; i++) sym[i] = 8'h00;
        send_cw();
        chk("zero_cw", m_codeword, 0);
        chk("zero_valid", m_valid, 1);

        for (int n = 0; n < 6; n++) begin
            rand_sym();
            for (int b = 0; b < NB; b++) begin
                chk("b2b_s_ready", s_ready, 1);
                beat_of(b, bd);
                beat(bd, b == NB - 1);
            end
            chk("b2b_valid", m_valid, 1);
            chk("b2b_cw", m_codeword, model());
        end
        idle();
        chk("drained", m_valid, 0);

        m_ready = 1'b0;
        rand_sym();
        send_cw();
        saved = model();
        chk("bp_cw", m_codeword, saved);
        rand_sym();
        beat_of(0, bd);
        s_valid = 1'b1;
        s_data  = bd;
        for (int c = 0; c < 5; c++) begin
            idle();
            chk("bp_s_ready", s_ready, 0);
            chk("bp_valid", m_valid, 1);
            chk("bp_stable", m_codeword, saved);
        end
        m_ready = 1'b1;
        #1;
        chk("bp_release", s_ready, 1);
        send_cw();
        chk("bp_next_cw", m_codeword, model());
        idle();

        rand_sym();
        beat_of(0, bd);
        beat(bd, 1'b0);
        beat_of(1, bd);
        beat(bd, 1'b1);
        chk("ferr_pulse", err, 1);
        chk("ferr_cnt", err_cnt, 1);
        chk("ferr_no_valid", m_valid, 0);
        idle();
        chk("ferr_one_cycle", err, 0);
        chk("ferr_no_valid2", m_valid, 0);
        rand_sym();
        send_cw();
        chk("ferr_recover_cw", m_codeword, model());
        chk("ferr_recover_valid", m_valid, 1);
        for (int b = 0; b < NB; b++) begin
            beat_of(b, bd);
            beat(bd, 1'b0);
        end
        chk("nolast_err", err, 1);
        chk("nolast_cnt", err_cnt, 2);
        idle();

        for (int i = 0; i < K; i++) sym[i] = 8'($urandom);
        beat_of(0, bd);
        beat(bd, 1'b0);
        beat_of(1, bd);
        beat(bd, 1'b0);
        rst = 1'b1;
        #2;
        chk("mid_rst_valid", m_valid, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        for (int i = 0; i < K; i++) sym[i] = 8'(i + 1);
        send_cw();
        chk("post_rst_cw", m_codeword, 80'h0102030405060708_0805);
        chk("post_rst_err_cnt", err_cnt, 0);
        chk("post_rst_err", err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
